// File: rtl/event_stat_accum_if.sv
// Event stream and snapshot handshake bundle for event_stat_accum.
// master: event producer / snapshot consumer; slave: the accumulator.
interface event_stat_accum_if #(
    parameter int unsigned NCH = 4,
    parameter int unsigned AW  = 16,
    parameter int unsigned CW  = 16
) ();
    localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic               ev_valid;
    logic               ev_ready;
    logic [CHW-1:0]     ev_chan;
    logic [AW-1:0]      ev_amp;

    logic               stat_valid;
    logic               stat_ready;
    logic [NCH*AW-1:0]  stat_peak;
    logic [NCH*CW-1:0]  stat_count;
    logic [NCH-1:0]     stat_sat;
    logic [7:0]         stat_seq;
    logic [7:0]         drop_cnt;

    modport master (
        output ev_valid, ev_chan, ev_amp, stat_ready,
        input  ev_ready, stat_valid, stat_peak, stat_count, stat_sat, stat_seq, drop_cnt
    );

    modport slave (
        input  ev_valid, ev_chan, ev_amp, stat_ready,
        output ev_ready, stat_valid, stat_peak, stat_count, stat_sat, stat_seq, drop_cnt
    );
endinterface

// File: rtl/event_stat_accum.sv
// Windowed per-channel peak/count accumulator; emits one valid/ready snapshot per window.
module event_stat_accum #(
    parameter int unsigned NCH     = 4,
    parameter int unsigned AW      = 16,
    parameter int unsigned CW      = 16,
    parameter int unsigned WIN_LEN = 1000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              enable,
    event_stat_accum_if.slave bus
);
    localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned WW  = $clog2(WIN_LEN);
    localparam logic [WW-1:0] WIN_LAST = WW'(WIN_LEN - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e            state_q;
    logic [WW-1:0]     win_cnt_q;
    logic [AW-1:0]     peak_q  [NCH];
    logic [CW-1:0]     count_q [NCH];
    logic [NCH-1:0]    sat_q;

    logic [AW-1:0]     peak_nx  [NCH];
    logic [CW-1:0]     count_nx [NCH];
    logic [NCH-1:0]    sat_nx;
    logic [NCH*AW-1:0] snap_peak;
    logic [NCH*CW-1:0] snap_count;

    logic              stat_valid_q;
    logic [NCH*AW-1:0] stat_peak_q;
    logic [NCH*CW-1:0] stat_count_q;
    logic [NCH-1:0]    stat_sat_q;
    logic [7:0]        stat_seq_q;
    logic [7:0]        seq_next_q;
    logic [7:0]        drop_q;

    logic accept;
    logic win_end;

    assign accept  = bus.ev_valid && (state_q == StRun);
    assign win_end = (state_q == StRun) && (win_cnt_q == WIN_LAST);

    // Working set with this cycle's event merged in; feeds both the update and the snapshot.
    always_comb begin
        sat_nx     = sat_q;
        snap_peak  = '0;
        snap_count = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            peak_nx[c]  = peak_q[c];
            count_nx[c] = count_q[c];
            if (accept && (bus.ev_chan == CHW'(c))) begin
                if (bus.ev_amp > peak_q[c]) begin
                    peak_nx[c] = bus.ev_amp;
                end
                if (count_q[c] == CNT_MAX) begin
                    sat_nx[c] = 1'b1;
                end else begin
                    count_nx[c] = count_q[c] + CW'(1);
                end
            end
            snap_peak[c*AW +: AW]  = peak_nx[c];
            snap_count[c*CW +: CW] = count_nx[c];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            win_cnt_q    <= '0;
            sat_q        <= '0;
            for (int unsigned c = 0; c < NCH; c++) begin
                peak_q[c]  <= '0;
                count_q[c] <= '0;
            end
            stat_valid_q <= 1'b0;
            stat_peak_q  <= '0;
            stat_count_q <= '0;
            stat_sat_q   <= '0;
            stat_seq_q   <= '0;
            seq_next_q   <= '0;
            drop_q       <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    win_cnt_q <= '0;
                    if (enable) begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (win_end) begin
                        win_cnt_q <= '0;
                        sat_q     <= '0;
                        for (int unsigned c = 0; c < NCH; c++) begin
                            peak_q[c]  <= '0;
                            count_q[c] <= '0;
                        end
                        if (!enable) begin
                            state_q <= StIdle;
                        end
                    end else begin
                        win_cnt_q <= win_cnt_q + WW'(1);
                        sat_q     <= sat_nx;
                        for (int unsigned c = 0; c < NCH; c++) begin
                            peak_q[c]  <= peak_nx[c];
                            count_q[c] <= count_nx[c];
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase

            // A blocked snapshot is dropped but still consumes a sequence number.
            if (win_end) begin
                seq_next_q <= seq_next_q + 8'd1;
                if (!stat_valid_q || bus.stat_ready) begin
                    stat_valid_q <= 1'b1;
                    stat_peak_q  <= snap_peak;
                    stat_count_q <= snap_count;
                    stat_sat_q   <= sat_nx;
                    stat_seq_q   <= seq_next_q;
                end else if (drop_q != 8'hFF) begin
                    drop_q <= drop_q + 8'd1;
                end
            end else if (stat_valid_q && bus.stat_ready) begin
                stat_valid_q <= 1'b0;
            end
        end
    end

    assign bus.ev_ready   = (state_q == StRun);
    assign bus.stat_valid = stat_valid_q;
    assign bus.stat_peak  = stat_peak_q;
    assign bus.stat_count = stat_count_q;
    assign bus.stat_sat   = stat_sat_q;
    assign bus.stat_seq   = stat_seq_q;
    assign bus.drop_cnt   = drop_q;
endmodule

// File: tb/tb_event_stat_accum.sv
// Directed, table-driven bench for event_stat_accum with WIN_LEN=16 and CW=4.
module tb_event_stat_accum;
    localparam int unsigned NCH     = 4;
    localparam int unsigned AW      = 16;
    localparam int unsigned CW      = 4;
    localparam int unsigned WIN_LEN = 16;
    localparam int          NVEC    = 12;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    logic enable = 1'b0;

    event_stat_accum_if #(.NCH(NCH), .AW(AW), .CW(CW)) bus ();

    event_stat_accum #(
        .NCH    (NCH),
        .AW     (AW),
        .CW     (CW),
        .WIN_LEN(WIN_LEN)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .enable(enable),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // One group = len consecutive events on one channel with one amplitude, from cycle start.
    typedef struct packed {
        logic [4:0]    start;
        logic [4:0]    len;
        logic [1:0]    ch;
        logic [AW-1:0] amp;
    } grp_t;

    typedef struct {
        grp_t              g [4];
        logic [NCH*AW-1:0] peak;
        logic [NCH*CW-1:0] count;
        logic [NCH-1:0]    sat;
    } win_vec_t;

    win_vec_t vt [NVEC];
    int n_tests = 0;
    int n_fail  = 0;

    function automatic grp_t grp(input int s, input int l, input int ch, input int amp);
        grp_t r;
        r.start = 5'(s);
        r.len   = 5'(l);
        r.ch    = 2'(ch);
        r.amp   = AW'(amp);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_snap(input int w, input int seq);
        chk($sformatf("w%0d valid", w), 64'(bus.stat_valid), 64'd1);
        chk($sformatf("w%0d peak", w),  64'(bus.stat_peak),  64'(vt[w].peak));
        chk($sformatf("w%0d count", w), 64'(bus.stat_count), 64'(vt[w].count));
        chk($sformatf("w%0d sat", w),   64'(bus.stat_sat),   64'(vt[w].sat));
        chk($sformatf("w%0d seq", w),   64'(bus.stat_seq),   64'(seq));
    endtask

    task automatic check_zero(input string name);
        chk({name, " valid"},    64'(bus.stat_valid), 64'd0);
        chk({name, " ev_ready"}, 64'(bus.ev_ready),   64'd0);
        chk({name, " peak"},     64'(bus.stat_peak),  64'd0);
        chk({name, " count"},    64'(bus.stat_count), 64'd0);
        chk({name, " sat"},      64'(bus.stat_sat),   64'd0);
        chk({name, " seq"},      64'(bus.stat_seq),   64'd0);
        chk({name, " drop"},     64'(bus.drop_cnt),   64'd0);
    endtask

    // Drives one full window starting at counter 0; returns #1 after the window-ending edge.
    task automatic run_window(input int w, input int en_off_at, input int rdy_off_at);
        for (int t = 0; t < int'(WIN_LEN); t++) begin
            if (t == en_off_at)  enable = 1'b0;
            if (t == rdy_off_at) bus.stat_ready = 1'b0;
            bus.ev_valid = 1'b0;
            bus.ev_chan  = '0;
            bus.ev_amp   = '0;
            for (int j = 0; j < 4; j++) begin
                if (t >= int'(vt[w].g[j].start) &&
                    t < int'(vt[w].g[j].start) + int'(vt[w].g[j].len)) begin
                    bus.ev_valid = 1'b1;
                    bus.ev_chan  = vt[w].g[j].ch;
                    bus.ev_amp   = vt[w].g[j].amp;
                end
            end
            @(posedge clk);
            #1;
        end
        bus.ev_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NVEC; i++) begin
            for (int j = 0; j < 4; j++) vt[i].g[j] = '0;
            vt[i].peak  = '0;
            vt[i].count = '0;
            vt[i].sat   = '0;
        end
        vt[1].g[0] = grp(0, 1, 0, 5);
        vt[1].g[1] = grp(1, 1, 0, 200);
        vt[1].g[2] = grp(2, 1, 0, 17);
        vt[1].g[3] = grp(3, 1, 3, 9);
        vt[1].peak  = {16'd9, 16'd0, 16'd0, 16'd200};
        vt[1].count = {4'd1, 4'd0, 4'd0, 4'd3};
        vt[3].g[0] = grp(14, 1, 1, 7);
        vt[3].g[1] = grp(15, 1, 1, 42);
        vt[3].peak  = {16'd0, 16'd0, 16'd42, 16'd0};
        vt[3].count = {4'd0, 4'd0, 4'd2, 4'd0};
        vt[4].g[0] = grp(0, 16, 2, 3);
        vt[4].peak  = {16'd0, 16'd3, 16'd0, 16'd0};
        vt[4].count = {4'd0, 4'd15, 4'd0, 4'd0};
        vt[4].sat   = 4'b0100;
        vt[5].g[0] = grp(7, 1, 2, 1);
        vt[5].peak  = {16'd0, 16'd1, 16'd0, 16'd0};
        vt[5].count = {4'd0, 4'd1, 4'd0, 4'd0};
        vt[6].g[0] = grp(4, 1, 0, 16'hFFFF);
        vt[6].g[1] = grp(6, 5, 1, 10);
        vt[6].g[2] = grp(0, 1, 3, 100);
        vt[6].g[3] = grp(12, 1, 3, 50);
        vt[6].peak  = {16'd100, 16'd0, 16'd10, 16'hFFFF};
        vt[6].count = {4'd2, 4'd0, 4'd5, 4'd1};
        vt[7].g[0] = grp(3, 2, 1, 77);
        vt[7].peak  = {16'd0, 16'd0, 16'd77, 16'd0};
        vt[7].count = {4'd0, 4'd0, 4'd2, 4'd0};
        vt[8].g[0] = grp(0, 1, 1, 99);
        vt[8].peak  = {16'd0, 16'd0, 16'd99, 16'd0};
        vt[8].count = {4'd0, 4'd0, 4'd1, 4'd0};
        vt[9].g[0] = grp(5, 3, 2, 5);
        vt[9].peak  = {16'd0, 16'd5, 16'd0, 16'd0};
        vt[9].count = {4'd0, 4'd3, 4'd0, 4'd0};
        vt[10].g[0] = grp(15, 1, 0, 1);
        vt[10].peak  = {16'd0, 16'd0, 16'd0, 16'd1};
        vt[10].count = {4'd0, 4'd0, 4'd0, 4'd1};
        vt[11].g[0] = grp(2, 1, 3, 4);
        vt[11].g[1] = grp(10, 1, 0, 33);
        vt[11].peak  = {16'd4, 16'd0, 16'd0, 16'd33};
        vt[11].count = {4'd1, 4'd0, 4'd0, 4'd1};

        bus.ev_valid   = 1'b0;
        bus.ev_chan    = '0;
        bus.ev_amp     = '0;
        bus.stat_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        resetn = 1'b1;
        @(posedge clk);
        #1;
        chk("idle ev_ready", 64'(bus.ev_ready), 64'd0);

        enable = 1'b1;
        @(posedge clk);
        #1;
        chk("run ev_ready", 64'(bus.ev_ready), 64'd1);

        // Free-running windows with the consumer always ready.
        for (int w = 0; w < 7; w++) begin
            run_window(w, -1, -1);
            check_snap(w, w);
        end

        // Backpressure across three window ends: first held, two dropped.
        run_window(7, -1, 1);
        check_snap(7, 7);
        chk("bp0 drop", 64'(bus.drop_cnt), 64'd0);
        run_window(8, -1, -1);
        check_snap(7, 7);
        chk("bp1 drop", 64'(bus.drop_cnt), 64'd1);
        run_window(9, -1, -1);
        check_snap(7, 7);
        chk("bp2 drop", 64'(bus.drop_cnt), 64'd2);
        bus.stat_ready = 1'b1;
        run_window(10, -1, -1);
        check_snap(10, 10);
        chk("bp release drop", 64'(bus.drop_cnt), 64'd2);

        // Enable drops mid-window: window still completes and is emitted, then idle.
        run_window(11, 5, -1);
        check_snap(11, 11);
        chk("stop ev_ready", 64'(bus.ev_ready), 64'd0);
        bus.stat_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle hold ev_ready", 64'(bus.ev_ready), 64'd0);
        check_snap(11, 11);

        // Reset mid-window with a pending snapshot and a populated working set.
        enable = 1'b1;
        @(posedge clk);
        #1;
        chk("rerun ev_ready", 64'(bus.ev_ready), 64'd1);
        bus.ev_valid = 1'b1;
        bus.ev_chan  = 2'd2;
        bus.ev_amp   = 16'd500;
        repeat (6) @(posedge clk);
        #1;
        resetn = 1'b0;
        #2;
        check_zero("midreset");
        @(posedge clk);
        #1;
        bus.ev_valid   = 1'b0;
        bus.stat_ready = 1'b1;
        resetn         = 1'b1;
        enable         = 1'b1;
        @(posedge clk);
        #1;
        run_window(2, -1, -1);
        check_snap(2, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
